// File: rtl/cpu_flags_pkg.sv
// Shared flag definitions for the flag owner tracker and its checkpoint FIFO.
// Entry typedef is sized for the two-lane, three-flag configuration.
package cpu_flags_pkg;

    localparam int unsigned FLAG_N  = 2;
    localparam int unsigned FLAG_V  = 1;
    localparam int unsigned FLAG_Z  = 0;
    localparam int unsigned OWNER_W = 1;

    typedef logic [2:0] flags_t;

    typedef struct packed {
        flags_t               flags;
        logic [OWNER_W-1:0]   owner;
    } ckpt_entry_t;

    // A single lane still needs a one-bit owner field.
    function automatic int unsigned owner_width(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/flag_owner_tracker_if.sv
// Bundle of lane flag writes, checkpoint controls and tracker status outputs.
interface flag_owner_tracker_if #(
    parameter int unsigned LANES      = 2,
    parameter int unsigned FLAG_W     = 3,
    parameter int unsigned CKPT_DEPTH = 2
);
    localparam int unsigned OWNER_W = cpu_flags_pkg::owner_width(LANES);
    localparam int unsigned CNT_W   = $clog2(CKPT_DEPTH) + 1;

    logic [LANES-1:0]        loads;
    logic [LANES-1:0]        lane_kill;
    logic [LANES*FLAG_W-1:0] flags_wr;
    logic                    ckpt_save;
    logic                    ckpt_release;
    logic                    ckpt_restore;
    logic [FLAG_W-1:0]       flags_out;
    logic [OWNER_W-1:0]      owner;
    logic [CNT_W-1:0]        ckpt_count;
    logic                    ckpt_full;
    logic                    ckpt_empty;
    logic                    ckpt_overflow;

    modport master (
        output loads, lane_kill, flags_wr, ckpt_save, ckpt_release, ckpt_restore,
        input  flags_out, owner, ckpt_count, ckpt_full, ckpt_empty, ckpt_overflow
    );

    modport slave (
        input  loads, lane_kill, flags_wr, ckpt_save, ckpt_release, ckpt_restore,
        output flags_out, owner, ckpt_count, ckpt_full, ckpt_empty, ckpt_overflow
    );

endinterface

// File: rtl/flag_ckpt_fifo.sv
// Checkpoint FIFO: push at tail, pop at head, clear, with a sticky overflow
// flag. A separate occupancy count keeps full and empty unambiguous.
module flag_ckpt_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 4,
    localparam int unsigned CntW = $clog2(Depth) + 1,
    localparam int unsigned PtrW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] head_o,
    output logic [CntW-1:0]  count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overflow_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             full, empty, push_ok, pop_ok;

    assign full  = (count_q == CntW'(Depth));
    assign empty = (count_q == '0);

    // A push into a full FIFO is accepted only when a pop frees a slot.
    assign push_ok = push_i & (~full | pop_i) & ~clear_i;
    assign pop_ok  = pop_i & ~empty & ~clear_i;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push_i & full & ~pop_i & ~clear_i);
        if (clear_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) tail_d = tail_q + 1'b1;
            if (pop_ok)  head_d = head_q + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[tail_q] <= data_i;
    end

    assign head_o     = mem_q[head_q];
    assign count_o    = count_q;
    assign full_o     = full;
    assign empty_o    = empty;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/flag_owner_tracker.sv
// Tracks the youngest lane to write N/V/Z flags, holds the architectural flag
// copy and checkpoints it so a flush can roll younger flag writes back.
module flag_owner_tracker
    import cpu_flags_pkg::*;
#(
    parameter int unsigned LANES      = 2,
    parameter int unsigned FLAG_W     = 3,
    parameter int unsigned CKPT_DEPTH = 2,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    flag_owner_tracker_if.slave  bus
);

    localparam int unsigned OWNER_W = owner_width(LANES);
    localparam int unsigned ENTRY_W = FLAG_W + OWNER_W;
    localparam int unsigned CNT_W   = $clog2(CKPT_DEPTH) + 1;

    logic [LANES-1:0]   eff;
    logic [OWNER_W-1:0] winner;
    logic [FLAG_W-1:0]  flags_q, flags_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic [ENTRY_W-1:0] head_entry;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full, fifo_empty, fifo_overflow;

    assign eff = bus.loads & ~bus.lane_kill;

    // Higher lane index is younger, so the last set bit wins.
    always_comb begin
        winner = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (eff[i]) winner = OWNER_W'(i);
        end
    end

    always_comb begin
        flags_d = flags_q;
        owner_d = owner_q;
        if (bus.ckpt_restore) begin
            if (!fifo_empty) {flags_d, owner_d} = head_entry;
        end else if (|eff) begin
            flags_d = bus.flags_wr[int'(winner)*FLAG_W +: FLAG_W];
            owner_d = winner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
            owner_q <= '0;
        end else begin
            flags_q <= flags_d;
            owner_q <= owner_d;
        end
    end

    // Restore overrides save and release in the same cycle.
    flag_ckpt_fifo #(
        .Depth (CKPT_DEPTH),
        .Width (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (bus.ckpt_save & ~bus.ckpt_restore),
        .pop_i      (bus.ckpt_release & ~bus.ckpt_restore),
        .clear_i    (bus.ckpt_restore & ~fifo_empty),
        .data_i     ({flags_d, owner_d}),
        .head_o     (head_entry),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .overflow_o (fifo_overflow)
    );

    assign bus.flags_out     = ((BYPASS != 0) && rst_n) ? flags_d : flags_q;
    assign bus.owner         = owner_q;
    assign bus.ckpt_count    = fifo_count;
    assign bus.ckpt_full     = fifo_full;
    assign bus.ckpt_empty    = fifo_empty;
    assign bus.ckpt_overflow = fifo_overflow;

endmodule

// File: doc/flag_owner_tracker.md
Name: flag_owner_tracker

Overview:
- Parametrised successor to the two-lane flag-indicate FSM.
- Tracks which of LANES issue lanes produced the youngest N/V/Z flag update and keeps a registered architectural flag copy.
- Holds a small checkpoint FIFO so flags can be restored when a delayed branch or flush discards younger flag writes.
- Sits in the CPU top between the lanes' flag-writing stage and the BGU and lane flag inputs.

Parameters:
- LANES, 2, number of issue lanes; a higher index is younger in program order within a cycle.
- FLAG_W, 3, flag vector width, packed {N,V,Z}.
- CKPT_DEPTH, 2, number of checkpoint entries (power of two, at least 2).
- BYPASS, 1, 1: a same-cycle flag write is visible combinationally on flags_out; 0: flags_out is registered only.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- loads, in, LANES, per-lane "this instruction writes flags this cycle".
- lane_kill, in, LANES, per-lane squash; masks loads for the same bit.
- flags_wr, in, LANES*FLAG_W, new flag value per lane; lane i occupies bits [i*FLAG_W +: FLAG_W].
- ckpt_save, in, 1, push a checkpoint of the post-update flags and owner.
- ckpt_release, in, 1, drop the oldest checkpoint (branch resolved, no rollback).
- ckpt_restore, in, 1, roll back to the oldest checkpoint and clear all entries.
- flags_out, out, FLAG_W, current architectural flags.
- owner, out, $clog2(LANES) (min 1), lane that last wrote flags.
- ckpt_count, out, $clog2(CKPT_DEPTH)+1, number of occupied entries.
- ckpt_full, out, 1, ckpt_count == CKPT_DEPTH.
- ckpt_empty, out, 1, ckpt_count == 0.
- ckpt_overflow, out, 1, sticky error flag.

Behaviour:
- Reset (rst_n low, asynchronous): flags_q=0, owner=0, FIFO pointers=0, ckpt_count=0, ckpt_overflow=0.
- Outputs during reset: flags_out=0, owner=0, ckpt_empty=1, ckpt_full=0.
- Effective write mask: eff = loads & ~lane_kill.
- Winner: the highest-index set bit of eff. This generalises the rule that the younger lane wins when both write.
- When eff != 0, at the clock edge: flags_q <= flags_wr[winner], owner <= winner.
- When eff == 0: flags_q and owner hold.
- Next-state values: nxt_flags and nxt_owner are the values flags_q and owner would take at this edge.
- flags_out:
  - BYPASS=1: nxt_flags (zero-latency forward of the winning write).
  - BYPASS=0: flags_q (one-cycle latency).
  - flags_out equals flags_q whenever ckpt_restore is low and eff == 0.
- Save: ckpt_save pushes {nxt_flags, nxt_owner} at the tail, so a write in the same cycle as the branch is included.
- Save when full: the push is dropped and ckpt_overflow sets. ckpt_overflow clears only on reset.
- Release: ckpt_release pops the head. Release when empty is ignored with no error.
- Save and release in the same cycle on a non-empty FIFO: both take effect and count is unchanged.
- Save and release in the same cycle on an empty FIFO: the save takes effect and count becomes 1.
- Restore: ckpt_restore with the FIFO non-empty loads flags_q and owner from the head entry, then empties the FIFO.
- Restore when empty: no state change except that loads in that cycle are still dropped.
- Restore priority: restore beats loads, save and release in the same cycle. All three are dropped that cycle.
- Restore and flags_out: during a restore cycle with BYPASS=1, flags_out shows the restored value combinationally.
- Pointers: head and tail wrap modulo CKPT_DEPTH. ckpt_count is kept separately, so full and empty are never ambiguous.
- Reset mid-operation: all checkpoints are lost and no restore is implied.

Decomposition:
- Shared package cpu_flags_pkg:
  - FLAG_N/FLAG_V/FLAG_Z bit indices.
  - typedef flags_t (logic [2:0]).
  - typedef ckpt_entry_t struct {flags_t flags; logic [OWNER_W-1:0] owner}.
- One natural sub-module: flag_ckpt_fifo (parametrised depth, push/pop/clear, count, full/empty, overflow).
- Winner selection is a plain priority encoder and stays inline.

Test Plan:
- Reset then idle, LANES=2 -> flags_out=000, owner=0, ckpt_empty=1, ckpt_overflow=0.
- loads=2'b11, flags_wr lane0=3'b100, lane1=3'b001 -> owner=1, flags_out=001 same cycle (BYPASS=1) and on the next cycle; again with lane_kill=2'b10 -> owner=0, flags=100.
- flags=010, then ckpt_save with loads=01 and lane0=3'b101; then two cycles writing 3'b111 and 3'b000; then ckpt_restore -> flags_out=101, owner=0, ckpt_count=0.
- CKPT_DEPTH=2: three saves without release -> ckpt_count=2, ckpt_full=1, ckpt_overflow=1; the third entry never appears on a later restore.
- Save+release in the same cycle with count=1 -> count stays 1 and the head becomes the new entry; release on empty -> count 0, no overflow.
- Restore, loads=10 (value 011) and ckpt_save all in one cycle with head {110,0} -> flags_out=110, owner=0, count=0; assert rst_n low mid-sequence -> all outputs return to reset values asynchronously.
